// File: rtl/fp_sched_pkg.sv
// Shared opcode, state and sizing definitions for the FP operation scheduler.
package fp_sched_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Latency counter must be able to hold LATENCY-1 and never be zero-width.
  function automatic int cntWidth(input int latency);
    int w;
    w = $clog2(latency + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester that did not win last time wins a tie.
module rr_arb2
  import fp_sched_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  assign grant_o[0] = enable_i & req_i[0] & (~req_i[1] | last_grant_i);
  assign grant_o[1] = enable_i & req_i[1] & (~req_i[0] | ~last_grant_i);

endmodule

// File: rtl/fp_op_scheduler.sv
// Time-shares one external FP unit between two requesters, holding operands
// for a fixed latency and presenting the captured result on a response channel.
module fp_op_scheduler
  import fp_sched_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int OP_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_para1,
  input  logic [WIDTH-1:0] req0_para2,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_para1,
  input  logic [WIDTH-1:0] req1_para2,
  input  logic [OP_W-1:0]  req1_op,
  output logic [WIDTH-1:0] unit_para1,
  output logic [WIDTH-1:0] unit_para2,
  output logic [OP_W-1:0]  unit_op,
  input  logic [WIDTH-1:0] unit_out,
  input  logic             unit_under_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_flag,
  output logic             rsp_err,
  output logic             rsp_id,
  output logic             busy
);

  localparam int CNT_W = cntWidth(LATENCY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lastGrant_q, lastGrant_d;
  logic [WIDTH-1:0] para1_q, para1_d;
  logic [WIDTH-1:0] para2_q, para2_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] rspData_q, rspData_d;
  logic             rspFlag_q, rspFlag_d;
  logic             rspErr_q, rspErr_d;
  logic             rspId_q, rspId_d;

  logic [1:0]       grant;
  logic             selId;
  logic [WIDTH-1:0] selPara1, selPara2;
  logic [OP_W-1:0]  selOp;

  // Arbitration is suppressed during reset so no ready pulse escapes while rst is high.
  rr_arb2 u_arb (
    .req_i        ({req1_valid, req0_valid}),
    .last_grant_i (lastGrant_q),
    .enable_i     ((state_q == ST_IDLE) & ~rst),
    .grant_o      (grant)
  );

  assign selId    = grant[1];
  assign selPara1 = selId ? req1_para1 : req0_para1;
  assign selPara2 = selId ? req1_para2 : req0_para2;
  assign selOp    = selId ? req1_op    : req0_op;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lastGrant_d = lastGrant_q;
    para1_d     = para1_q;
    para2_d     = para2_q;
    op_d        = op_q;
    rspData_d   = rspData_q;
    rspFlag_d   = rspFlag_q;
    rspErr_d    = rspErr_q;
    rspId_d     = rspId_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          para1_d     = selPara1;
          para2_d     = selPara2;
          lastGrant_d = selId;
          rspId_d     = selId;
          if (selOp == OP_W'(OP_ILL)) begin
            // Illegal opcodes skip the unit entirely and present MUL to it.
            op_d      = OP_W'(OP_MUL);
            rspErr_d  = 1'b1;
            rspData_d = '0;
            rspFlag_d = 1'b0;
            state_d   = ST_DONE;
          end else begin
            op_d    = selOp;
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          rspData_d = unit_out;
          rspFlag_d = unit_under_overflow;
          rspErr_d  = 1'b0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lastGrant_q <= 1'b1;
      para1_q     <= '0;
      para2_q     <= '0;
      op_q        <= '0;
      rspData_q   <= '0;
      rspFlag_q   <= 1'b0;
      rspErr_q    <= 1'b0;
      rspId_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lastGrant_q <= lastGrant_d;
      para1_q     <= para1_d;
      para2_q     <= para2_d;
      op_q        <= op_d;
      rspData_q   <= rspData_d;
      rspFlag_q   <= rspFlag_d;
      rspErr_q    <= rspErr_d;
      rspId_q     <= rspId_d;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign unit_para1 = para1_q;
  assign unit_para2 = para2_q;
  assign unit_op    = op_q;
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_data   = rspData_q;
  assign rsp_flag   = rspFlag_q;
  assign rsp_err    = rspErr_q;
  assign rsp_id     = rspId_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_op_scheduler.sv
// Directed bench for fp_op_scheduler with a table-driven stand-in for the FP unit.
module tb_fp_op_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0Valid, req1Valid;
  logic        req0Ready, req1Ready;
  logic [31:0] req0Para1, req0Para2, req1Para1, req1Para2;
  logic [1:0]  req0Op, req1Op;
  logic [31:0] unitPara1, unitPara2, unitOut;
  logic [1:0]  unitOp;
  logic        unitFlag;
  logic        rspValid, rspReady, rspFlag, rspErr, rspId, busy;
  logic [31:0] rspData;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_op_scheduler #(.WIDTH(32), .LATENCY(1), .OP_W(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req0_valid          (req0Valid),
    .req0_ready          (req0Ready),
    .req0_para1          (req0Para1),
    .req0_para2          (req0Para2),
    .req0_op             (req0Op),
    .req1_valid          (req1Valid),
    .req1_ready          (req1Ready),
    .req1_para1          (req1Para1),
    .req1_para2          (req1Para2),
    .req1_op             (req1Op),
    .unit_para1          (unitPara1),
    .unit_para2          (unitPara2),
    .unit_op             (unitOp),
    .unit_out            (unitOut),
    .unit_under_overflow (unitFlag),
    .rsp_valid           (rspValid),
    .rsp_ready           (rspReady),
    .rsp_data            (rspData),
    .rsp_flag            (rspFlag),
    .rsp_err             (rspErr),
    .rsp_id              (rspId),
    .busy                (busy)
  );

  // Only the operand combinations used below are known; anything else returns a marker.
  always_comb begin
    unitOut  = 32'hDEADBEEF;
    unitFlag = 1'b0;
    if (unitOp == 2'b00 && unitPara1 == 32'h3FC00000 && unitPara2 == 32'h40000000)
      unitOut = 32'h40400000;
    else if (unitOp == 2'b01 && unitPara1 == 32'h3F800000 && unitPara2 == 32'h3F800000)
      unitOut = 32'h40000000;
    else if (unitOp == 2'b10 && unitPara1 == 32'h40400000 && unitPara2 == 32'h3F800000)
      unitOut = 32'h40000000;
    else if (unitOp == 2'b00 && unitPara1 == 32'h7F000000 && unitPara2 == 32'h7F000000) begin
      unitOut  = 32'h7F800000;
      unitFlag = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [1:0] op0,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [1:0] op1,
                               input logic [31:0] a1, input logic [31:0] b1);
    req0Valid = v0; req0Op = op0; req0Para1 = a0; req0Para2 = b0;
    req1Valid = v1; req1Op = op1; req1Para1 = a1; req1Para2 = b1;
  endtask

  initial begin
    rst = 1'b1;
    rspReady = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (2) @(posedge clk);

    // Reset state
    @(negedge clk);
    checkOutput("rst_rsp_valid", rspValid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_req0_ready", req0Ready, 0);
    checkOutput("rst_req1_ready", req1Ready, 0);
    checkOutput("rst_unit_para1", unitPara1, 0);
    checkOutput("rst_rsp_data", rspData, 0);

    // Single MUL from requester 0
    rst = 1'b0;
    rspReady = 1'b1;
    applyStimulus(1'b1, 2'b00, 32'h3FC00000, 32'h40000000, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    checkOutput("mul_req0_ready", req0Ready, 1);
    checkOutput("mul_req1_ready", req1Ready, 0);
    @(negedge clk);
    req0Valid = 1'b0;
    checkOutput("mul_busy_c1", busy, 1);
    checkOutput("mul_valid_c1", rspValid, 0);
    checkOutput("mul_unit_para1", unitPara1, 32'h3FC00000);
    checkOutput("mul_unit_op", unitOp, 2'b00);
    @(negedge clk);
    checkOutput("mul_busy_c2", busy, 1);
    checkOutput("mul_valid_c2", rspValid, 1);
    checkOutput("mul_data", rspData, 32'h40400000);
    checkOutput("mul_id", rspId, 0);
    checkOutput("mul_err", rspErr, 0);
    @(negedge clk);
    checkOutput("mul_busy_after", busy, 0);
    checkOutput("mul_valid_after", rspValid, 0);

    // Illegal opcode from requester 1
    rspReady = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b11, 32'h12345678, 32'h9ABCDEF0);
    #1;
    checkOutput("ill_req1_ready", req1Ready, 1);
    @(negedge clk);
    checkOutput("ill_valid_c1", rspValid, 1);
    checkOutput("ill_err", rspErr, 1);
    checkOutput("ill_data", rspData, 0);
    checkOutput("ill_flag", rspFlag, 0);
    checkOutput("ill_id", rspId, 1);
    checkOutput("ill_unit_op", unitOp, 2'b00);
    checkOutput("ill_busy", busy, 1);
    req1Valid = 1'b0;
    rspReady = 1'b1;
    @(negedge clk);
    checkOutput("ill_busy_after", busy, 0);
    checkOutput("ill_valid_after", rspValid, 0);

    // Continuous dual ADD requests must alternate grants starting with requester 0
    applyStimulus(1'b1, 2'b01, 32'h3F800000, 32'h3F800000,
                  1'b1, 2'b01, 32'h3F800000, 32'h3F800000);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("rr%0d_req0_ready", k), req0Ready, (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("rr%0d_req1_ready", k), req1Ready, (k % 2 == 1) ? 1 : 0);
      @(negedge clk);
      checkOutput($sformatf("rr%0d_busy", k), busy, 1);
      checkOutput($sformatf("rr%0d_ready_in_busy", k), req0Ready | req1Ready, 0);
      @(negedge clk);
      checkOutput($sformatf("rr%0d_valid", k), rspValid, 1);
      checkOutput($sformatf("rr%0d_data", k), rspData, 32'h40000000);
      checkOutput($sformatf("rr%0d_id", k), rspId, k % 2);
      checkOutput($sformatf("rr%0d_err", k), rspErr, 0);
      @(negedge clk);
    end
    req0Valid = 1'b0;
    req1Valid = 1'b0;

    // Overflowing MUL, response held while the consumer stalls
    rspReady = 1'b0;
    applyStimulus(1'b1, 2'b00, 32'h7F000000, 32'h7F000000, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    checkOutput("hold_req0_ready", req0Ready, 1);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, 32'h40400000, 32'h3F800000, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("hold%0d_valid", c), rspValid, 1);
      checkOutput($sformatf("hold%0d_data", c), rspData, 32'h7F800000);
      checkOutput($sformatf("hold%0d_flag", c), rspFlag, 1);
      checkOutput($sformatf("hold%0d_req0_ready", c), req0Ready, 0);
      checkOutput($sformatf("hold%0d_unit_para1", c), unitPara1, 32'h7F000000);
      @(negedge clk);
    end
    rspReady = 1'b1;
    #1;
    checkOutput("hold_release_req0_ready", req0Ready, 0);
    @(negedge clk);
    #1;
    checkOutput("hold_idle_busy", busy, 0);
    checkOutput("hold_idle_req0_ready", req0Ready, 1);
    @(negedge clk);
    checkOutput("sub_unit_para1", unitPara1, 32'h40400000);
    checkOutput("sub_unit_op", unitOp, 2'b10);

    // Reset while BUSY discards the operation and restores requester-0 priority
    rst = 1'b1;
    req0Valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", rspValid, 0);
    checkOutput("abort_unit_para1", unitPara1, 0);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort_no_rsp", rspValid, 0);
    end
    applyStimulus(1'b1, 2'b00, 32'h3FC00000, 32'h40000000,
                  1'b1, 2'b01, 32'h3F800000, 32'h3F800000);
    #1;
    checkOutput("post_rst_req0_ready", req0Ready, 1);
    checkOutput("post_rst_req1_ready", req1Ready, 0);
    @(negedge clk);
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    checkOutput("post_rst_unit_para1", unitPara1, 32'h3FC00000);
    @(negedge clk);
    checkOutput("post_rst_valid", rspValid, 1);
    checkOutput("post_rst_data", rspData, 32'h40400000);
    checkOutput("post_rst_id", rspId, 0);
    @(negedge clk);
    checkOutput("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_op_scheduler.md
Name: fp_op_scheduler

Overview:
- Shares one floating-point arithmetic unit (multiply/add/sub, 32-bit) between two requesters.
- Round-robin arbitration between requester 0 and requester 1; valid/ready handshakes on each request and on the single response channel.
- Holds the unit's operands stable for a fixed latency, then captures its result and flag.
- Sits between the ALU front-end requesters and the FP datapath.
- The datapath is combinational or fixed-latency, with outputs `out` and `under_overflow`.

Parameters:
- WIDTH, 32, operand and result width.
- LATENCY, 1, cycles the unit inputs are held before the result is sampled (≥1).
- OP_W, 2, opcode width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_para1  input  WIDTH  requester 0 operand A.
- req0_para2  input  WIDTH  requester 0 operand B.
- req0_op  input  OP_W  requester 0 opcode.
- req1_valid  input  1  requester 1 has an operation.
- req1_ready  output  1  requester 1 accepted this cycle.
- req1_para1  input  WIDTH  requester 1 operand A.
- req1_para2  input  WIDTH  requester 1 operand B.
- req1_op  input  OP_W  requester 1 opcode.
- unit_para1  output  WIDTH  operand A to the FP unit.
- unit_para2  output  WIDTH  operand B to the FP unit.
- unit_op  output  OP_W  opcode to the FP unit.
- unit_out  input  WIDTH  FP unit result.
- unit_under_overflow  input  1  FP unit under/overflow flag.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes the response.
- rsp_data  output  WIDTH  result.
- rsp_flag  output  1  captured under/overflow.
- rsp_err  output  1  illegal opcode.
- rsp_id  output  1  requester that issued the operation.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Opcodes: 00 MUL, 01 ADD, 10 SUB, 11 illegal.
- States:
  - IDLE: no operation in flight.
  - BUSY: operands held on the unit; latency counter running.
  - DONE: response presented on the response channel.
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE; all rsp_* = 0; busy=0.
  - unit_para1, unit_para2, unit_op = 0.
  - Latency counter = 0.
  - last_grant=1, so requester 0 wins the first contention.
- Reset mid-operation: the in-flight operation is discarded and no response is produced.
- IDLE accept rules:
  - reqN_ready is combinational and asserted only in IDLE, to exactly one requester with valid=1.
  - Both valid: grant the requester ≠ last_grant.
  - One valid: grant it regardless of last_grant.
  - No valid: neither ready.
- On accept (edge):
  - Latch para1, para2 and op into the operand registers that drive unit_*.
  - rsp_id ← granted index; last_grant ← granted index.
  - Legal op: counter ← LATENCY-1, next state BUSY.
  - Illegal op (11): next state DONE with rsp_err=1, rsp_data=0, rsp_flag=0; unit_op is driven 00 and the unit is not waited on.
- BUSY:
  - unit_* stay constant.
  - Counter decrements each cycle.
  - At counter==0: rsp_data←unit_out, rsp_flag←unit_under_overflow, rsp_err←0, next state DONE.
  - BUSY lasts exactly LATENCY cycles.
- DONE:
  - rsp_valid=1; rsp_* are stable until the handshake.
  - rsp_valid && rsp_ready at an edge → IDLE, rsp_valid←0. The other fields may retain their values.
  - rsp_ready low holds DONE indefinitely. No new request is accepted (reqN_ready=0).
- Latency:
  - Accept in cycle 0 → rsp_valid first high in cycle LATENCY+1 for legal ops, cycle 1 for illegal ops.
  - Minimum back-to-back issue interval is LATENCY+2 cycles, since the next accept happens in IDLE after the response handshake.
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1…
- A requester that drops valid before being granted loses nothing. The arbiter re-evaluates every IDLE cycle.
- Operand registers are not updated outside the accept edge.

Decomposition:
- Package fp_sched_pkg:
  - Opcode localparams OP_MUL, OP_ADD, OP_SUB, OP_ILL.
  - State encoding ST_IDLE, ST_BUSY, ST_DONE.
  - Counter width function ceil(log2(LATENCY+1)).
- Sub-module rr_arb2:
  - Inputs: 2 requests, last_grant, enable.
  - Outputs: one-hot grant.
  - Purely combinational; instantiated once.
- The FP unit is instantiated outside this block.

Test Plan:
- Reset with rst=1 for 2 cycles → rsp_valid=0, busy=0, req0_ready=req1_ready=0, unit_para1=0.
- req0 MUL 0x3FC00000×0x40000000 with LATENCY=1 → req0_ready in cycle 0, busy for 2 cycles, rsp_valid in cycle 2 with rsp_data=0x40400000, rsp_id=0, rsp_err=0.
- req0 and req1 both valid with ADD 0x3F800000+0x3F800000, held across 4 operations → grant order 0,1,0,1; each response rsp_data=0x40000000 with rsp_id alternating.
- req1 op=11 → rsp_valid in cycle 1, rsp_err=1, rsp_data=0, rsp_id=1; busy drops after the handshake.
- rsp_ready held 0 for 5 cycles in DONE → rsp_* stable, req0_ready stays 0 despite req0_valid=1; accept occurs in the cycle after rsp_ready=1 returns the block to IDLE.
- rst pulsed while in BUSY → next cycle IDLE, rsp_valid never asserted for the aborted op, and the following req0 is granted first (last_grant=1).
